// File: rtl/stage2_classifier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stage2_classifier_pkg
//  Description : Shared constants, state encoding and the score saturation
//                helper for the output-layer classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package stage2_classifier_pkg;

   localparam int HID     = 20;          // hidden nodes feeding each output neuron
   localparam int OUT     = 10;          // output classes
   localparam int DW      = 16;          // Q6.10 data width
   localparam int FRAC    = 10;          // fractional bits
   localparam int ACC_W   = 38;          // accumulator width
   localparam int W_DEPTH = HID * OUT;   // weight memory entries
   localparam int WA_W    = 8;           // weight address width
   localparam int BA_W    = 4;           // bias address width
   localparam int NW      = 4;           // neuron counter width
   localparam int JW      = 5;           // node counter width

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MAC   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_BIAS  = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   // Drop the fractional scaling of a product sum and clip to the Q6.10 range.
   function automatic logic [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] s;
      logic [DW-1:0]           r;
      s = acc >>> FRAC;
      if (s > ACC_W'(32767))
         r = 16'h7FFF;
      else if (s < ACC_W'(-32768))
         r = 16'h8000;
      else
         r = s[DW-1:0];
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stage2_classifier_param_ram.sv
`default_nettype none
// ============================================================================
//  Module      : param_ram
//  Description : Simple dual-port parameter store: one write port and one
//                synchronous read port with single-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_ram #(
   parameter int DEPTH = 200,
   parameter int WIDTH = 16,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Contents are never reset; the read register holds its value when re is low.
   always_ff @(posedge clk) begin
      if (we)
         mem_q[waddr] <= wdata;
      if (re)
         rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/stage2_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : stage2_classifier
//  Description : Output layer of the digit recogniser. Snapshots the hidden
//                activations, evaluates ten neurons with a single MAC and
//                reports the arg-max class and its score.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage2_classifier
   import stage2_classifier_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                stage1_done,
   input  logic [HID*DW-1:0]   hidden_in,
   input  logic [DW-1:0]       w23_wrdata,
   input  logic [WA_W-1:0]     wr_w23addr,
   input  logic                we_w23,
   input  logic [DW-1:0]       b23_wrdata,
   input  logic [BA_W-1:0]     wr_b23addr,
   input  logic                we_b23,
   output logic                busy,
   output logic                stage2_done,
   output logic [3:0]          digit,
   output logic [DW-1:0]       score_max,
   output logic [OUT*DW-1:0]   scores
);

   state_t                  state_q, state_d;
   logic [NW-1:0]           n_q, n_d;
   logic [JW-1:0]           j_q, j_d;
   logic [JW-1:0]           j_dly_q, j_dly_d;
   logic                    mac_vld_q, mac_vld_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [DW-1:0]    snap_q [HID];
   logic signed [DW-1:0]    snap_d [HID];
   logic [OUT*DW-1:0]       scores_q, scores_d;
   logic [DW-1:0]           max_val_q, max_val_d;
   logic [NW-1:0]           max_idx_q, max_idx_d;
   logic [3:0]              digit_q, digit_d;
   logic [DW-1:0]           score_max_q, score_max_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    s1_prev_q;

   logic [WA_W-1:0]         w_waddr_rd;
   logic [DW-1:0]           w_wdata_rd;
   logic [DW-1:0]           w_bdata_rd;
   logic                    w_w_re;
   logic                    w_b_re;
   logic                    w_accept;
   logic signed [DW-1:0]    w_hid;
   logic signed [DW-1:0]    w_wt;
   logic signed [DW-1:0]    w_bias;
   logic signed [2*DW-1:0]  w_prod;
   logic signed [ACC_W-1:0] w_acc_b;
   logic [DW-1:0]           w_score;

   assign w_waddr_rd = WA_W'(n_q) * WA_W'(HID) + WA_W'(j_q);
   assign w_w_re     = (state_q == ST_MAC);
   assign w_b_re     = (state_q == ST_MAC) && (j_q == '0);

   param_ram #(.DEPTH(W_DEPTH), .WIDTH(DW), .AW(WA_W)) u_w23_ram (
      .clk   (clk),
      .we    (we_w23),
      .waddr (wr_w23addr),
      .wdata (w23_wrdata),
      .re    (w_w_re),
      .raddr (w_waddr_rd),
      .rdata (w_wdata_rd)
   );

   param_ram #(.DEPTH(OUT), .WIDTH(DW), .AW(BA_W)) u_b23_ram (
      .clk   (clk),
      .we    (we_b23),
      .waddr (wr_b23addr),
      .wdata (b23_wrdata),
      .re    (w_b_re),
      .raddr (n_q),
      .rdata (w_bdata_rd)
   );

   // Weight data arrives one cycle after its address, so the node index is
   // delayed alongside it to pick the matching snapshot entry.
   assign w_accept = stage1_done & ~s1_prev_q & (state_q == ST_IDLE);
   assign w_hid    = snap_q[j_dly_q];
   assign w_wt     = w_wdata_rd;
   assign w_bias   = w_bdata_rd;
   assign w_prod   = 32'(w_hid) * 32'(w_wt);
   assign w_acc_b  = acc_q + (ACC_W'(w_bias) <<< FRAC);
   assign w_score  = sat_shift(w_acc_b);

   // Next-state, counter and datapath updates for the run sequencer.
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      j_d         = j_q;
      j_dly_d     = j_q;
      mac_vld_d   = (state_q == ST_MAC);
      acc_d       = acc_q;
      snap_d      = snap_q;
      scores_d    = scores_q;
      max_val_d   = max_val_q;
      max_idx_d   = max_idx_q;
      digit_d     = digit_q;
      score_max_d = score_max_q;
      busy_d      = busy_q;
      done_d      = done_q;

      if (mac_vld_q)
         acc_d = acc_q + ACC_W'(w_prod);

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               for (int k = 0; k < HID; k++)
                  snap_d[k] = hidden_in[k*DW +: DW];
               busy_d  = 1'b1;
               done_d  = 1'b0;
               n_d     = '0;
               j_d     = '0;
               acc_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            j_d = j_q + 1'b1;
            if (j_q == JW'(HID - 1))
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_d = ST_BIAS;
         end
         ST_BIAS: begin
            scores_d[32'(n_q)*DW +: DW] = w_score;
            // Strict compare keeps the lowest index on ties.
            if ((n_q == '0) || ($signed(w_score) > $signed(max_val_q))) begin
               max_val_d = w_score;
               max_idx_d = n_q;
            end
            acc_d = '0;
            j_d   = '0;
            if (n_q == NW'(OUT - 1)) begin
               state_d = ST_FIN;
            end else begin
               n_d     = n_q + 1'b1;
               state_d = ST_MAC;
            end
         end
         ST_FIN: begin
            digit_d     = max_idx_q;
            score_max_d = max_val_q;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any run in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         n_q         <= '0;
         j_q         <= '0;
         j_dly_q     <= '0;
         mac_vld_q   <= 1'b0;
         acc_q       <= '0;
         for (int k = 0; k < HID; k++)
            snap_q[k] <= '0;
         scores_q    <= '0;
         max_val_q   <= '0;
         max_idx_q   <= '0;
         digit_q     <= '0;
         score_max_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         s1_prev_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         j_q         <= j_d;
         j_dly_q     <= j_dly_d;
         mac_vld_q   <= mac_vld_d;
         acc_q       <= acc_d;
         snap_q      <= snap_d;
         scores_q    <= scores_d;
         max_val_q   <= max_val_d;
         max_idx_q   <= max_idx_d;
         digit_q     <= digit_d;
         score_max_q <= score_max_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         s1_prev_q   <= stage1_done;
      end
   end

   assign busy        = busy_q;
   assign stage2_done = done_q;
   assign digit       = digit_q;
   assign score_max   = score_max_q;
   assign scores      = scores_q;

endmodule
`default_nettype wire

// File: tb/tb_stage2_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage2_classifier
//  Description : Directed self-checking bench for the output-layer classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage2_classifier;
   import stage2_classifier_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic                stage1_done;
   logic [HID*DW-1:0]   hidden_in;
   logic [DW-1:0]       w23_wrdata;
   logic [WA_W-1:0]     wr_w23addr;
   logic                we_w23;
   logic [DW-1:0]       b23_wrdata;
   logic [BA_W-1:0]     wr_b23addr;
   logic                we_b23;
   logic                busy;
   logic                stage2_done;
   logic [3:0]          digit;
   logic [DW-1:0]       score_max;
   logic [OUT*DW-1:0]   scores;

   int n_assert = 0;
   int n_fail   = 0;

   stage2_classifier dut (
      .clk         (clk),
      .reset       (reset),
      .stage1_done (stage1_done),
      .hidden_in   (hidden_in),
      .w23_wrdata  (w23_wrdata),
      .wr_w23addr  (wr_w23addr),
      .we_w23      (we_w23),
      .b23_wrdata  (b23_wrdata),
      .wr_b23addr  (wr_b23addr),
      .we_b23      (we_b23),
      .busy        (busy),
      .stage2_done (stage2_done),
      .digit       (digit),
      .score_max   (score_max),
      .scores      (scores)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [OUT*DW-1:0] obs, input logic [OUT*DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr_w(input int addr, input logic [DW-1:0] data);
      @(negedge clk);
      wr_w23addr = WA_W'(addr);
      w23_wrdata = data;
      we_w23     = 1'b1;
      @(posedge clk);
      #1 we_w23 = 1'b0;
   endtask

   task automatic wr_b(input int addr, input logic [DW-1:0] data);
      @(negedge clk);
      wr_b23addr = BA_W'(addr);
      b23_wrdata = data;
      we_b23     = 1'b1;
      @(posedge clk);
      #1 we_b23 = 1'b0;
   endtask

   function automatic logic [HID*DW-1:0] fill(input logic [DW-1:0] v);
      logic [HID*DW-1:0] r;
      for (int k = 0; k < HID; k++)
         r[k*DW +: DW] = v;
      return r;
   endfunction

   // Raise stage1_done and count cycles until results appear. lat = cycle index
   // at which stage2_done is first seen high (acceptance cycle = 0), -1 on
   // timeout, -2 if stopped early at abort_at. stage1_done is left high.
   task automatic run(input int pulse_at, input int abort_at, output int lat);
      lat = -1;
      @(negedge clk);
      stage1_done = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            chk("busy_after_accept", busy, 1);
            chk("done_low_after_accept", stage2_done, 0);
            hidden_in = ~hidden_in;   // post-capture change must be ignored
         end
         if (pulse_at > 0 && c == pulse_at - 2) stage1_done = 1'b0;
         if (pulse_at > 0 && c == pulse_at)     stage1_done = 1'b1;
         if (abort_at > 0 && c == abort_at) begin
            lat = -2;
            break;
         end
         if (stage2_done) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      logic [OUT*DW-1:0] e;

      reset = 1'b0; stage1_done = 1'b0; hidden_in = '0;
      w23_wrdata = '0; wr_w23addr = '0; we_w23 = 1'b0;
      b23_wrdata = '0; wr_b23addr = '0; we_b23 = 1'b0;

      // Asynchronous reset asserted mid-cycle
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", stage2_done, 0);
      chk("rst_digit", digit, 0);
      chk("rst_score_max", score_max, 0);
      chk("rst_scores", scores, 0);
      @(negedge clk) reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", stage2_done, 0);
      chk("idle_scores", scores, 0);

      for (int a = 0; a < W_DEPTH; a++) wr_w(a, 16'h0000);
      for (int b = 0; b < OUT; b++)     wr_b(b, 16'h0000);

      // Bias only
      wr_b(7, 16'h0400);
      hidden_in = fill(16'h1234);
      run(0, 0, lat);
      chk("bias_latency", lat, 222);
      e = '0; e[7*DW +: DW] = 16'h0400;
      chk("bias_scores", scores, e);
      chk("bias_digit", digit, 7);
      chk("bias_score_max", score_max, 16'h0400);
      @(negedge clk) stage1_done = 1'b0;

      // Dot product: 20 * 1.0 * 1.0 - 1.0 = 19.0
      wr_b(7, 16'h0000);
      wr_b(3, 16'hFC00);
      for (int j = 0; j < HID; j++) wr_w(3*HID + j, 16'h0400);
      hidden_in = fill(16'h0400);
      run(0, 0, lat);
      chk("dot_latency", lat, 222);
      e = '0; e[3*DW +: DW] = 16'h4C00;
      chk("dot_scores", scores, e);
      chk("dot_digit", digit, 3);
      chk("dot_score_max", score_max, 16'h4C00);
      @(negedge clk) stage1_done = 1'b0;

      // Saturation both ways, with a stage1_done re-pulse mid-run
      wr_b(3, 16'h0000);
      for (int j = 0; j < HID; j++) wr_w(3*HID + j, 16'h0000);
      for (int j = 0; j < HID; j++) wr_w(5*HID + j, 16'h7FFF);
      for (int j = 0; j < HID; j++) wr_w(2*HID + j, 16'h8000);
      hidden_in = fill(16'h7FFF);
      run(50, 0, lat);
      chk("sat_latency_with_pulse", lat, 222);
      e = '0; e[5*DW +: DW] = 16'h7FFF; e[2*DW +: DW] = 16'h8000;
      chk("sat_scores", scores, e);
      chk("sat_digit", digit, 5);
      chk("sat_score_max", score_max, 16'h7FFF);

      // stage1_done held high: no second run, results stay visible
      repeat (10) @(posedge clk);
      #1;
      chk("hold_busy", busy, 0);
      chk("hold_done", stage2_done, 1);
      chk("hold_scores", scores, e);
      @(negedge clk) stage1_done = 1'b0;

      // All zero: tie among every class resolves to class 0
      for (int j = 0; j < HID; j++) wr_w(5*HID + j, 16'h0000);
      for (int j = 0; j < HID; j++) wr_w(2*HID + j, 16'h0000);
      run(0, 0, lat);
      chk("zero_latency", lat, 222);
      chk("zero_scores", scores, 0);
      chk("zero_digit", digit, 0);
      chk("zero_score_max", score_max, 0);
      @(negedge clk) stage1_done = 1'b0;

      // Equal biases on classes 4 and 8: lower index wins
      wr_b(4, 16'h0200);
      wr_b(8, 16'h0200);
      run(0, 0, lat);
      chk("tie_latency", lat, 222);
      e = '0; e[4*DW +: DW] = 16'h0200; e[8*DW +: DW] = 16'h0200;
      chk("tie_scores", scores, e);
      chk("tie_digit", digit, 4);
      chk("tie_score_max", score_max, 16'h0200);
      @(negedge clk) stage1_done = 1'b0;

      // Reset in the middle of a run
      run(0, 100, lat);
      chk("abort_reached", lat, -2);
      reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", stage2_done, 0);
      chk("abort_digit", digit, 0);
      chk("abort_score_max", score_max, 0);
      chk("abort_scores", scores, 0);
      @(negedge clk);
      reset = 1'b0;
      stage1_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_idle_busy", busy, 0);

      // Restart after the abort
      run(0, 0, lat);
      chk("restart_latency", lat, 222);
      chk("restart_scores", scores, e);
      chk("restart_digit", digit, 4);
      chk("restart_score_max", score_max, 16'h0200);
      @(negedge clk) stage1_done = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stage2_classifier.md
Name: stage2_classifier

Overview:
- Output layer of the digit-recognition inference engine; sits directly downstream of the hidden-layer stage.
- Consumes the 20 hidden activations (signed Q6.10) when the hidden-layer stage's done level rises.
- Computes 10 output scores as hidden x w23 + b23 with one MAC per cycle, then reports the argmax as the recognised digit.
- Weight and bias storage is internal and loaded by the bench through dedicated write ports.

Parameters:
HID, 20, number of hidden nodes (inputs per output neuron)
OUT, 10, number of output classes
DW, 16, data width of activations, weights, biases and scores
FRAC, 10, fractional bits of the Q6.10 format
ACC_W, 38, accumulator width (32-bit product, 20-term growth, bias headroom)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stage1_done  in  1  level from the hidden-layer stage; its rising edge starts a run
hidden_in  in  HID*DW  hidden activations, node j at [16j+15:16j], signed Q6.10
w23_wrdata  in  16  weight write data, signed Q6.10
wr_w23addr  in  8  weight write address = n*HID + j (0..199)
we_w23  in  1  weight write enable
b23_wrdata  in  16  bias write data, signed Q6.10
wr_b23addr  in  4  bias write address n (0..9)
we_b23  in  1  bias write enable
busy  out  1  high while a run is in progress
stage2_done  out  1  level; rises when results are valid and holds until the next accepted start
digit  out  4  index of the maximum score
score_max  out  16  maximum score, signed Q6.10
scores  out  OUT*DW  all scores, class n at [16n+15:16n]

Behaviour:
- Reset (async, active-high): state IDLE. busy, stage2_done, digit, score_max, scores, accumulator, counters and the hidden snapshot all 0. Memory contents are not cleared.
- Start: stage1_done is registered each cycle. A run is accepted when the current sample is 1, the previous sample is 0 and state is IDLE.
  - In that cycle hidden_in is captured into a 20-entry snapshot register.
  - busy goes to 1, stage2_done goes to 0, and the neuron counter n and node counter j go to 0.
- States: IDLE -> MAC -> DRAIN -> BIAS -> (MAC for next n | FIN) -> IDLE.
- Weight and bias memories: synchronous read, 1-cycle latency. Reads are independent of the write ports.
- MAC: each cycle presents weight address n*HID+j; j increments.
  - The product snapshot[j_d] * w is 32-bit signed, where j_d and w are one cycle delayed.
  - The sign-extended product is added to the ACC_W accumulator.
  - Bias address n is presented on the cycle j=0.
  - After j=HID-1, go to DRAIN.
- DRAIN: accumulate the last product.
- BIAS:
  - Add (sign-extended bias) << FRAC.
  - Form s = acc >>> FRAC, saturated to [-32768, 32767], and write it into scores[n].
  - Compare with the running max using strict greater-than; class 0 always initialises the max. Ties therefore keep the lowest index.
  - Clear acc and j. Go to MAC with n+1, or to FIN if n = OUT-1.
- FIN: register digit and score_max, set stage2_done=1 and busy=0, go to IDLE.
- Latency: stage2_done rises exactly 1 + OUT*(HID+2) + 1 = 222 cycles after the start-acceptance cycle (defaults).
- Boundary conditions:
  - A stage1_done rising edge while busy is ignored; no restart and no queueing.
  - Changes to hidden_in after capture have no effect.
  - Memory writes during busy are permitted but the result is undefined; the bench must not do this.
  - reset mid-run aborts immediately to the reset values. The next start runs normally.
  - stage1_done held high produces no second run until it falls and rises again.
  - scores and digit from the previous run remain visible until overwritten by the next run.

Decomposition:
- Shared package holds:
  - constants HID, OUT, DW, FRAC, ACC_W;
  - state encoding IDLE/MAC/DRAIN/BIAS/FIN;
  - the saturate-shift function (acc >>> FRAC clipped to 16 bits).
- Sub-module param_ram: parameterised depth/width, single write port plus single synchronous read port. Instantiated twice: 200x16 weights, 10x16 biases.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0 immediately. Release, no start -> outputs stay 0 and busy=0.
- Bias only:
  - Stimulus: weights all 0, bias[7]=0x0400, other biases 0, any hidden_in, then raise stage1_done.
  - Required: busy=1 the next cycle; stage2_done exactly 222 cycles after acceptance; digit=7, score_max=1024, scores[7]=1024, all other scores 0.
- Dot product:
  - Stimulus: hidden all 0x0400; w23[3*20+j]=0x0400 for all j; all other weights 0; bias[3]=0xFC00 (-1.0).
  - Required: scores[3]=19456 (19.0), digit=3.
- Saturation and sign:
  - Stimulus: hidden all 0x7FFF; class-5 weights 0x7FFF; class-2 weights 0x8000.
  - Required: scores[5]=32767, scores[2]=-32768, digit=5.
- Ties: all weights and biases 0 -> all scores 0, digit=0. Setting class 4 and class 8 biases equal at 0x0200 -> digit=4.
- Robustness:
  - Pulse stage1_done low-high at cycle 50 of a run -> ignored, latency still 222.
  - Assert reset at cycle 100 of a run -> outputs 0, busy=0.
  - Restart after the reset -> correct result with 222-cycle latency.
